// File: rtl/uart_loop_fifo.sv
// Byte FIFO between the UART receiver and transmitter in the loopback path.
// Define UART_LOOP_FIFO_LEVEL_EN to expose the registered occupancy as fifo_level.
module uart_loop_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ACK_TO     = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              rx_done,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              tx_busy,
   output logic              tx_en,
   output logic [DATA_W-1:0] tx_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              ovf_flag,
   input  logic              ovf_clr
`ifdef UART_LOOP_FIFO_LEVEL_EN
   ,
   output logic [DEPTH_LOG2:0] fifo_level
`endif
);

   localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned         TO_W      = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
   localparam logic [DEPTH_LOG2:0] C_FULL    = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_ONE     = (DEPTH_LOG2+1)'(1);
   localparam logic [TO_W-1:0]     C_TO_LAST = TO_W'(ACK_TO - 1);
   localparam logic [TO_W-1:0]     C_TO_ONE  = TO_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} state_t;

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_tx_en;
   logic [DATA_W-1:0]     r_tx_data;
   logic                  r_ovf;
   logic                  r_empty;
   logic                  r_full;
   state_t                r_state;
   logic [TO_W-1:0]       r_to;

   state_t                w_state_nxt;
   logic [TO_W-1:0]       w_to_nxt;
   logic                  w_pop;
   logic                  w_wr_ok;
   logic                  w_drop;
   logic [DEPTH_LOG2:0]   w_count_nxt;

   // Acceptance looks only at the registered count, so a full FIFO drops even when a pop coincides.
   assign w_wr_ok = rx_done && (r_count != C_FULL);
   assign w_drop  = rx_done && (r_count == C_FULL);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
         r_to    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_to    <= w_to_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_to_nxt    = r_to;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && !tx_busy) begin
               w_pop       = 1'b1;
               w_to_nxt    = '0;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy)
               w_state_nxt = S_WAIT_DONE;
            else if (r_to == C_TO_LAST)
               w_state_nxt = S_IDLE;
            else
               w_to_nxt = r_to + C_TO_ONE;
         end
         S_WAIT_DONE: begin
            if (!tx_busy)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_ok && !w_pop)
         w_count_nxt = r_count + C_ONE;
      else if (!w_wr_ok && w_pop)
         w_count_nxt = r_count - C_ONE;
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr_ok)
         r_mem[r_wr_ptr] <= rx_data;
   end

   // Flags are computed from the next count so they track r_count without a cycle of lag.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
         r_ovf     <= 1'b0;
         r_empty   <= 1'b1;
         r_full    <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == C_FULL);
         r_tx_en <= w_pop;
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
         end
         if (w_drop)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign tx_en      = r_tx_en;
   assign tx_data    = r_tx_data;
   assign fifo_empty = r_empty;
   assign fifo_full  = r_full;
   assign ovf_flag   = r_ovf;
`ifdef UART_LOOP_FIFO_LEVEL_EN
   assign fifo_level = r_count;
`endif

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Scoreboard bench for uart_loop_fifo: stimulus queues expected tx bytes, a monitor checks each tx_en.
module tb_uart_loop_fifo;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = '0;
   logic       tx_busy = 1'b0;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       fifo_empty;
   logic       fifo_full;
   logic       ovf_flag;
   logic       ovf_clr = 1'b0;
`ifdef UART_LOOP_FIFO_LEVEL_EN
   logic [4:0] fifo_level;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_tx     = 0;
   int unsigned cyc      = 0;
   int unsigned tx_mode  = 0;   // 0: busy tied low, 1: busy pulse after each tx_en, 2: busy held high
   int unsigned busy_len = 20;
   int unsigned busy_cnt = 0;
   logic [7:0]  sb[$];
   int unsigned en_times[$];

   uart_loop_fifo #(.DEPTH_LOG2(4), .DATA_W(8), .ACK_TO(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_done(rx_done), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
`ifdef UART_LOOP_FIFO_LEVEL_EN
      , .fifo_level(fifo_level)
`endif
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic push(input logic [7:0] d, input bit expect_tx);
      rx_done = 1'b1;
      rx_data = d;
      if (expect_tx) sb.push_back(d);
      tick(1);
      rx_done = 1'b0;
   endtask

   task automatic drain(input string name, input int unsigned limit);
      int unsigned k = 0;
      while (k < limit && !(sb.size() == 0 && fifo_empty && !tx_busy)) begin
         tick(1);
         k++;
      end
      chk(name, (k < limit) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // Transmitter model
   initial forever begin
      @(negedge sys_clk);
      if (tx_mode == 2) begin
         tx_busy = 1'b1;
         busy_cnt = 0;
      end else if (tx_mode == 0) begin
         tx_busy = 1'b0;
         busy_cnt = 0;
      end else begin
         if (tx_en === 1'b1) busy_cnt = busy_len;
         if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   // Output monitor
   initial forever begin
      @(negedge sys_clk);
      if (tx_en === 1'b1) begin
         n_tx++;
         en_times.push_back(cyc);
         if (sb.size() == 0) chk("tx_en_unexpected", {31'd0, tx_en}, 32'd0);
         else chk("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned n0;
      tick(3);
      chk("rst_tx_en",  {31'd0, tx_en},      32'd0);
      chk("rst_tx_data",{24'd0, tx_data},    32'd0);
      chk("rst_empty",  {31'd0, fifo_empty}, 32'd1);
      chk("rst_full",   {31'd0, fifo_full},  32'd0);
      chk("rst_ovf",    {31'd0, ovf_flag},   32'd0);
      sys_rst = 1'b0;
      tick(2);

      // Single byte
      tx_mode = 1;
      tick(2);
      push(8'h55, 1'b1);
      chk("single_e0_tx_en", {31'd0, tx_en},      32'd0);
      chk("single_e0_empty", {31'd0, fifo_empty}, 32'd0);
      tick(1);
      chk("single_e1_tx_en", {31'd0, tx_en},      32'd1);
      chk("single_e1_data",  {24'd0, tx_data},    32'h55);
      chk("single_e1_empty", {31'd0, fifo_empty}, 32'd1);
      tick(1);
      chk("single_e2_tx_en", {31'd0, tx_en},      32'd0);
      tick(30);
      chk("single_tx_count", n_tx, 32'd1);

      // Overflow and flag clear
      tx_mode = 2;
      tick(2);
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
      chk("ovf_full16",  {31'd0, fifo_full}, 32'd1);
      chk("ovf_before",  {31'd0, ovf_flag},  32'd0);
      push(8'hAA, 1'b0);
      chk("ovf_set",     {31'd0, ovf_flag},  32'd1);
      chk("ovf_full17",  {31'd0, fifo_full}, 32'd1);
      ovf_clr = 1'b1;
      push(8'hBB, 1'b0);
      ovf_clr = 1'b0;
      chk("ovf_set_wins", {31'd0, ovf_flag}, 32'd1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared",  {31'd0, ovf_flag}, 32'd0);
      n0 = n_tx;
      tx_mode = 1;
      drain("ovf_drain_done", 1000);
      chk("ovf_tx_count", n_tx - n0, 32'd16);
      chk("ovf_not_full", {31'd0, fifo_full}, 32'd0);

      // Ack timeout with busy stuck low
      tx_mode = 0;
      tick(3);
      en_times.delete();
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      tick(15);
      chk("ack_pulses", en_times.size(), 32'd2);
      if (en_times.size() == 2) chk("ack_spacing", en_times[1] - en_times[0], 32'd5);
      chk("ack_empty", {31'd0, fifo_empty}, 32'd1);

      // Reset mid-transfer
      busy_len = 200;
      tx_mode = 1;
      tick(2);
      push(8'hC1, 1'b1);
      push(8'hC2, 1'b0);
      push(8'hC3, 1'b0);
      push(8'hC4, 1'b0);
      tick(3);
      chk("rst_mid_busy",  {31'd0, tx_busy},    32'd1);
      chk("rst_mid_empty", {31'd0, fifo_empty}, 32'd0);
      sys_rst = 1'b1;
      #1;
      chk("rstm_tx_en",   {31'd0, tx_en},      32'd0);
      chk("rstm_tx_data", {24'd0, tx_data},    32'd0);
      chk("rstm_empty",   {31'd0, fifo_empty}, 32'd1);
      chk("rstm_ovf",     {31'd0, ovf_flag},   32'd0);
      tx_mode = 0;
      tick(2);
      sys_rst = 1'b0;
      n0 = n_tx;
      tick(20);
      chk("rstm_no_tx", n_tx - n0, 32'd0);
      busy_len = 20;
      tx_mode = 1;
      push(8'h77, 1'b1);
      drain("rstm_new_byte", 200);
      chk("rstm_tx_count", n_tx - n0, 32'd1);

`ifdef UART_LOOP_FIFO_LEVEL_EN
      tx_mode = 2;
      tick(2);
      for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b1);
      chk("level_5", {27'd0, fifo_level}, 32'd5);
      tx_mode = 1;
      for (int k = 4; k >= 0; k--) begin
         int unsigned w = 0;
         tick(1);
         while (tx_en !== 1'b1 && w < 100) begin
            tick(1);
            w++;
         end
         chk("level_pop", {27'd0, fifo_level}, 32'(k));
      end
      drain("level_drain", 200);
`endif

      chk("sb_leftover", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
- Byte buffer between the UART receiver (rx byte-done pulse) and the UART transmitter (start pulse plus busy) in the loopback datapath.
- Absorbs back-to-back received bytes while the transmitter is still shifting, and re-launches them in arrival order.
- Flags bytes lost to overflow.
- Target: 50 MHz sys_clk, 115200 baud, so one byte takes about 4340 clocks on the line.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries (default 16).
- DATA_W, 8: byte width.
- ACK_TO, 4: cycles to wait for tx_busy to rise after a tx_en pulse before giving up.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- rx_done  in  1  single-cycle pulse; rx_data valid this cycle.
- rx_data  in  DATA_W  received byte.
- tx_busy  in  1  high while the transmitter is shifting a frame.
- tx_en  out  1  single-cycle start pulse to the transmitter.
- tx_data  out  DATA_W  byte to transmit; held from tx_en until the next tx_en.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == 2^DEPTH_LOG2.
- ovf_flag  out  1  sticky overflow indicator.
- ovf_clr  in  1  single-cycle clear of ovf_flag.

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, count = 0; FSM = IDLE; tx_en = 0; tx_data = 0x00; ovf_flag = 0; fifo_empty = 1; fifo_full = 0. Memory contents are not reset.
- Reset mid-transfer discards all buffered bytes. No tx_en is issued until a new rx_done arrives.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is DEPTH_LOG2+1 bits.
- Write rule:
  - On rx_done with registered count < depth: store rx_data at wr_ptr, increment wr_ptr.
  - On rx_done with count == depth: byte is dropped and ovf_flag is set. This applies even if a pop occurs in the same cycle.
- Count update: count += write_accepted − pop. A simultaneous accepted write and pop leaves count unchanged.
- ovf_flag: set on a dropped byte; cleared by ovf_clr. If set and clear coincide, set wins.
- fifo_empty and fifo_full are registered and derived from the updated count, with no extra cycle of lag.
- Read FSM, 3 states:
  - IDLE: if count != 0 and tx_busy == 0, pop at this edge: tx_data <= mem[rd_ptr], tx_en <= 1 for exactly one cycle, rd_ptr++, go to WAIT_ACK. Otherwise stay.
  - WAIT_ACK: if tx_busy == 1, go to WAIT_DONE. Otherwise increment the timeout counter; after ACK_TO cycles in this state without busy, go to IDLE. The popped byte is considered sent and is not retried.
  - WAIT_DONE: stay while tx_busy == 1; go to IDLE on tx_busy == 0.
- Latency: rx_done sampled at edge E0 into an empty FIFO with tx idle gives tx_en high between E1 and E2, with tx_data valid from E1.
- Minimum spacing between tx_en pulses is 3 cycles. With tx_busy stuck low, the spacing is ACK_TO+1 cycles.
- tx_data changes only on a pop edge.

Optional Feature:
- Macro: UART_LOOP_FIFO_LEVEL_EN.
- Defined: adds output port fifo_level (DEPTH_LOG2+1 bits), equal to the registered count and reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single byte: rx_done with 0x55; bench tx model raises busy 1 cycle after tx_en, for 20 cycles.
  - Required: one tx_en pulse at E0+1; tx_data = 0x55; fifo_empty 0 → 1 at the pop edge; no further tx_en.
- Overflow:
  - Hold tx_busy = 1 and push 0x00..0x0F: fifo_full = 1 after the 16th byte.
  - 17th byte 0xAA: dropped, ovf_flag = 1.
  - Release busy and pulse it per byte: tx_data sequence is exactly 0x00..0x0F; 0xAA never appears.
- Overflow flag clear:
  - ovf_clr pulsed in the same cycle as an overflowing rx_done: ovf_flag stays 1.
  - ovf_clr alone a cycle later: ovf_flag = 0.
- Ack timeout: tx_busy tied 0, push 0x11 then 0x22 back-to-back.
  - Required: two tx_en pulses 5 cycles apart (ACK_TO = 4), carrying 0x11 then 0x22; fifo_empty = 1 afterwards.
- Reset mid-transfer: 3 bytes buffered and FSM in WAIT_DONE; assert sys_rst for 2 cycles.
  - Required: immediately tx_en = 0, tx_data = 0x00, fifo_empty = 1, ovf_flag = 0.
  - After release with tx_busy = 0: no tx_en until a new rx_done.
- With UART_LOOP_FIFO_LEVEL_EN defined: push 5 bytes with busy held high.
  - Required: fifo_level = 5; decrements by 1 per pop after busy releases; reaches 0.
